ac_motor_bridge_pwm: RTL

Multi-channel sine/triangle PWM comparator with programmable dead time and per-channel half-bridge sequencing. It is the parametrised successor of the single-bridge AC motor comparator. One block drives CHANNELS half-bridges (default three-phase) from a shared triangle carrier and per-channel sine references. It adds run-time dead time, rotation reversal and a clean enable/disable sequence. It sits between the sine/triangle generators and the gate-driver pins.

---
 rtl/ac_motor_bridge_pwm.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ac_motor_bridge_pwm.sv
// ac_motor_bridge_pwm
//   Multi-channel sine/triangle PWM comparator driving CHANNELS half-bridges
//   from a shared triangle carrier. Each channel has its own half-bridge
//   sequencer that inserts a programmable dead interval between high-side and
//   low-side conduction.
//
// Ports
//   CLK        system clock, rising edge
//   RESET_N    asynchronous active-low reset
//   ENABLE     1 = bridges may conduct, 0 = all switches off
//   DIR        0 = forward channel mapping, 1 = reversed rotation
//   DEAD_TIME  dead interval in CLK cycles (0 behaves as 1)
//   TRIANGLE   signed carrier shared by all channels
//   SINE       packed signed references, channel k at [k*WIDTH +: WIDTH]
//   HI / LO    high-side / low-side gate per channel
//   DT_ACTIVE  1 while the channel sits in its dead interval
module ac_motor_bridge_pwm #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 24,
  parameter int DT_BITS  = 8
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      ENABLE,
  input  logic                      DIR,
  input  logic [DT_BITS-1:0]        DEAD_TIME,
  input  logic [WIDTH-1:0]          TRIANGLE,
  input  logic [CHANNELS*WIDTH-1:0] SINE,
  output logic [CHANNELS-1:0]       HI,
  output logic [CHANNELS-1:0]       LO,
  output logic [CHANNELS-1:0]       DT_ACTIVE
);

  typedef enum logic [1:0] {S_OFF, S_ON_HI, S_ON_LO, S_DEAD} state_t;

  // Stage 1: input registers
  logic [WIDTH-1:0]          tri_q;
  logic [CHANNELS*WIDTH-1:0] sine_q;
  logic                      dir_q;
  logic                      en_q;

  // Stage 2: per-channel demand
  logic [CHANNELS-1:0]       demand_c;
  logic [CHANNELS-1:0]       demand;

  // Stage 3: per-channel sequencers
  state_t                    state     [CHANNELS];
  state_t                    state_nxt [CHANNELS];
  logic [DT_BITS-1:0]        cnt       [CHANNELS];
  logic [DT_BITS-1:0]        cnt_nxt   [CHANNELS];
  logic [CHANNELS-1:0]       tgt;
  logic [CHANNELS-1:0]       tgt_nxt;
  logic [CHANNELS-1:0]       hi_d, lo_d, dt_d;
  logic [DT_BITS-1:0]        dt_load;

  assign dt_load = (DEAD_TIME == '0) ? DT_BITS'(1) : DEAD_TIME;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tri_q  <= '0;
      sine_q <= '0;
      dir_q  <= 1'b0;
      en_q   <= 1'b0;
      demand <= '0;
    end else begin
      tri_q  <= TRIANGLE;
      sine_q <= SINE;
      dir_q  <= DIR;
      en_q   <= ENABLE;
      demand <= demand_c;
    end
  end

  // Reversed rotation feeds channel k from sine (CHANNELS-k) mod CHANNELS,
  // which keeps channel 0 fixed and swaps the remaining phase order.
  always_comb begin
    int unsigned src;
    src      = 0;
    demand_c = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      src         = dir_q ? ((CHANNELS - k) % CHANNELS) : k;
      demand_c[k] = $signed(sine_q[src*WIDTH +: WIDTH]) >= $signed(tri_q);
    end
  end

  // State register; gate outputs are registered from the next state so they
  // change on the same edge as the sequencer state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        state[k] <= S_OFF;
        cnt[k]   <= '0;
      end
      tgt       <= '0;
      HI        <= '0;
      LO        <= '0;
      DT_ACTIVE <= '0;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        state[k] <= state_nxt[k];
        cnt[k]   <= cnt_nxt[k];
      end
      tgt       <= tgt_nxt;
      HI        <= hi_d;
      LO        <= lo_d;
      DT_ACTIVE <= dt_d;
    end
  end

  // Next-state logic. A demand change while dead retargets and reloads the
  // counter, so the interval is always measured from the latest change.
  always_comb begin
    tgt_nxt = tgt;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      state_nxt[k] = state[k];
      cnt_nxt[k]   = cnt[k];
      if (!en_q) begin
        state_nxt[k] = S_OFF;
        cnt_nxt[k]   = '0;
      end else begin
        case (state[k])
          S_OFF: begin
            state_nxt[k] = S_DEAD;
            tgt_nxt[k]   = demand[k];
            cnt_nxt[k]   = dt_load;
          end
          S_ON_HI: begin
            if (!demand[k]) begin
              state_nxt[k] = S_DEAD;
              tgt_nxt[k]   = 1'b0;
              cnt_nxt[k]   = dt_load;
            end
          end
          S_ON_LO: begin
            if (demand[k]) begin
              state_nxt[k] = S_DEAD;
              tgt_nxt[k]   = 1'b1;
              cnt_nxt[k]   = dt_load;
            end
          end
          S_DEAD: begin
            if (demand[k] != tgt[k]) begin
              tgt_nxt[k] = demand[k];
              cnt_nxt[k] = dt_load;
            end else if (cnt[k] <= DT_BITS'(1)) begin
              state_nxt[k] = tgt[k] ? S_ON_HI : S_ON_LO;
              cnt_nxt[k]   = '0;
            end else begin
              cnt_nxt[k] = cnt[k] - DT_BITS'(1);
            end
          end
          default: begin
            state_nxt[k] = S_OFF;
            cnt_nxt[k]   = '0;
          end
        endcase
      end
    end
  end

  // Output decode of the next state.
  always_comb begin
    hi_d = '0;
    lo_d = '0;
    dt_d = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      hi_d[k] = (state_nxt[k] == S_ON_HI);
      lo_d[k] = (state_nxt[k] == S_ON_LO);
      dt_d[k] = (state_nxt[k] == S_DEAD);
    end
  end

endmodule
